// File: rtl/param_register_file_pkg.sv
// param_register_file_pkg
// Shared definitions for the parameterised register file and for the older
// fixed 16-bit register file users, so every user decodes FunSel the same way.
//   fun_e          : function codes applied to enabled registers
//   is_wrap_event  : modulo-wrap detection for increment/decrement
package param_register_file_pkg;

    typedef enum logic [2:0] {
        FUN_DEC  = 3'b000,  // decrement, modulo 2^WIDTH
        FUN_INC  = 3'b001,  // increment, modulo 2^WIDTH
        FUN_LOAD = 3'b010,  // load full write data
        FUN_CLR  = 3'b011,  // clear to zero
        FUN_LDLO = 3'b100,  // low half of write data into low half
        FUN_LDHI = 3'b101,  // low half of write data into high half
        FUN_SHL  = 3'b110,  // shift left one, zero fill
        FUN_ASR  = 3'b111   // arithmetic shift right one, sign held
    } fun_e;

    // A wrap happens only when counting past either end of the range.
    function automatic logic is_wrap_event(input fun_e fun,
                                           input logic all_ones,
                                           input logic all_zero);
        return ((fun == FUN_INC) && all_ones) || ((fun == FUN_DEC) && all_zero);
    endfunction

endpackage

// File: rtl/param_register_file_register.sv
// param_register
// One WIDTH-bit register with its own function unit and sticky wrap flag.
//   Clock, Reset : clock, asynchronous active-low reset
//   en           : this register is enabled this cycle
//   fun          : function to apply when enabled
//   din          : write data
//   clr_wrap     : clears the sticky wrap flag (a same-edge wrap still sets it)
//   q            : current register value
//   next_q       : value the register takes at the coming edge (for forwarding)
//   wrap_flag    : sticky wrap indication
module param_register
    import param_register_file_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  fun_e             fun,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap_flag
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] fun_val;
    logic             wrap_evt;

    always_comb begin
        fun_val = q;
        case (fun)
            FUN_DEC:  fun_val = q - WIDTH'(1);
            FUN_INC:  fun_val = q + WIDTH'(1);
            FUN_LOAD: fun_val = din;
            FUN_CLR:  fun_val = '0;
            FUN_LDLO: fun_val = {q[WIDTH-1:HALF], din[HALF-1:0]};
            FUN_LDHI: fun_val = {din[HALF-1:0], q[HALF-1:0]};
            FUN_SHL:  fun_val = {q[WIDTH-2:0], 1'b0};
            FUN_ASR:  fun_val = {q[WIDTH-1], q[WIDTH-1:1]};
            default:  fun_val = q;
        endcase
    end

    assign next_q   = en ? fun_val : q;
    assign wrap_evt = en && is_wrap_event(fun, &q, ~|q);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q         <= '0;
            wrap_flag <= 1'b0;
        end else begin
            q         <= next_q;
            // set wins over clear when both happen on the same edge
            wrap_flag <= wrap_evt | (wrap_flag & ~clr_wrap);
        end
    end

endmodule

// File: rtl/param_register_file.sv
// param_register_file
// NREG x WIDTH register file; every enabled register applies FunSel to its
// own value each cycle, with two registered read ports.
//   Clock, Reset      : clock, asynchronous active-low reset
//   I                 : write data
//   RegSel            : per-register enable, active-low
//   FunSel            : function code (param_register_file_pkg::fun_e)
//   OutASel, OutBSel  : read-port register indices
//   RdEn, ClrWrap     : read request, clear all sticky wrap flags
//   OutA, OutB        : registered read data
//   OutValid          : read data valid
//   WrapFlag          : sticky per-register wrap flags
//
// Read handshake: there is no back-pressure. A cycle with RdEn = 1 is a
// request; the next cycle has OutValid = 1 and OutA/OutB carry the selected
// registers' values as they stand after that same edge's update. Outputs hold
// while RdEn = 0.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREG  = 8,
    localparam int SELW  = $clog2(NREG)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [NREG-1:0]  RegSel,
    input  logic [2:0]       FunSel,
    input  logic [SELW-1:0]  OutASel,
    input  logic [SELW-1:0]  OutBSel,
    input  logic             RdEn,
    input  logic             ClrWrap,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic             OutValid,
    output logic [NREG-1:0]  WrapFlag
);

    logic [WIDTH-1:0] reg_q   [NREG];
    logic [WIDTH-1:0] reg_nxt [NREG];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        param_register #(
            .WIDTH (WIDTH)
        ) u_reg (
            .Clock     (Clock),
            .Reset     (Reset),
            .en        (~RegSel[k]),
            .fun       (fun_e'(FunSel)),
            .din       (I),
            .clr_wrap  (ClrWrap),
            .q         (reg_q[k]),
            .next_q    (reg_nxt[k]),
            .wrap_flag (WrapFlag[k])
        );
    end

    // Selecting from next values gives write-to-read forwarding. An index with
    // no matching register leaves the default zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int k = 0; k < NREG; k++) begin
            if (OutASel == SELW'(k)) rd_a = reg_nxt[k];
            if (OutBSel == SELW'(k)) rd_b = reg_nxt[k];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            OutA     <= '0;
            OutB     <= '0;
            OutValid <= 1'b0;
        end else begin
            OutValid <= RdEn;
            if (RdEn) begin
                OutA <= rd_a;
                OutB <= rd_b;
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
    import param_register_file_pkg::*;

    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int SELW  = 3;

    logic             Clock;
    logic             Reset;
    logic [WIDTH-1:0] I;
    logic [NREG-1:0]  RegSel;
    logic [2:0]       FunSel;
    logic [SELW-1:0]  OutASel;
    logic [SELW-1:0]  OutBSel;
    logic             RdEn;
    logic             ClrWrap;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;
    logic             OutValid;
    logic [NREG-1:0]  WrapFlag;

    param_register_file #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .I        (I),
        .RegSel   (RegSel),
        .FunSel   (FunSel),
        .OutASel  (OutASel),
        .OutBSel  (OutBSel),
        .RdEn     (RdEn),
        .ClrWrap  (ClrWrap),
        .OutA     (OutA),
        .OutB     (OutB),
        .OutValid (OutValid),
        .WrapFlag (WrapFlag)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: plain integer arithmetic on the register contents
    int       m_reg [NREG];
    bit [7:0] m_wrap;
    int       m_a, m_b;
    bit       m_v;

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_reg[k] = 0;
        m_wrap = '0; m_a = 0; m_b = 0; m_v = 0;
    endtask

    task automatic model_step(input bit [7:0] regsel, input int fun, input int din,
                              input int asel, input int bsel, input bit rden, input bit clr);
        int nv [NREG];
        bit [7:0] ev;
        ev = '0;
        for (int k = 0; k < NREG; k++) begin
            int v;
            v = m_reg[k];
            nv[k] = v;
            if (!regsel[k]) begin
                case (fun)
                    0: begin if (v == 0) ev[k] = 1; nv[k] = (v + 65535) % 65536; end
                    1: begin if (v == 65535) ev[k] = 1; nv[k] = (v + 1) % 65536; end
                    2: nv[k] = din;
                    3: nv[k] = 0;
                    4: nv[k] = (v & 'hFF00) | (din & 'hFF);
                    5: nv[k] = ((din & 'hFF) * 256) | (v & 'hFF);
                    6: nv[k] = (v * 2) % 65536;
                    default: nv[k] = (v / 2) + ((v >= 32768) ? 32768 : 0);
                endcase
            end
        end
        m_wrap = (clr ? 8'h00 : m_wrap) | ev;
        if (rden) begin
            m_a = (asel < NREG) ? nv[asel] : 0;
            m_b = (bsel < NREG) ? nv[bsel] : 0;
        end
        m_v = rden;
        for (int k = 0; k < NREG; k++) m_reg[k] = nv[k];
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NREG; k++)
            check($sformatf("%s reg%0d", tag, k), 32'(dut.reg_q[k]), 32'(m_reg[k]));
    endtask

    // driver: apply one cycle, advance model, sample #1 after the edge
    task automatic drive(input logic [7:0] regsel, input logic [2:0] fun, input logic [15:0] din,
                         input logic [2:0] asel, input logic [2:0] bsel,
                         input logic rden, input logic clr);
        RegSel = regsel; FunSel = fun; I = din;
        OutASel = asel; OutBSel = bsel; RdEn = rden; ClrWrap = clr;
        model_step(regsel, int'(fun), int'(din), int'(asel), int'(bsel), rden, clr);
        @(posedge Clock);
        #1;
    endtask

    typedef struct {
        logic [7:0]  regsel;
        logic [2:0]  fun;
        logic [15:0] i;
        logic [2:0]  asel, bsel;
        logic        rden, clr;
        logic [15:0] ea, eb;
        logic        ev;
        logic [7:0]  ew;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{8'hF7, FUN_DEC,  16'h0000, 3'd3, 3'd3, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 8'h08};
        tbl[1]  = '{8'hFF, FUN_INC,  16'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 8'h00};
        tbl[2]  = '{8'hF7, FUN_INC,  16'h0000, 3'd3, 3'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h08};
        tbl[3]  = '{8'hFF, FUN_INC,  16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h08};
        tbl[4]  = '{8'hFF, FUN_INC,  16'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 8'h00};
        tbl[5]  = '{8'hFB, FUN_LOAD, 16'h1234, 3'd2, 3'd2, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b1, 8'h00};
        tbl[6]  = '{8'hFB, FUN_CLR,  16'h0000, 3'd2, 3'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h00};
        tbl[7]  = '{8'hF5, FUN_LOAD, 16'hABCD, 3'd1, 3'd3, 1'b1, 1'b0, 16'hABCD, 16'hABCD, 1'b1, 8'h00};
        tbl[8]  = '{8'hFF, FUN_LOAD, 16'hFFFF, 3'd0, 3'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h00};
        tbl[9]  = '{8'hFE, FUN_LOAD, 16'h1234, 3'd0, 3'd1, 1'b1, 1'b0, 16'h1234, 16'hABCD, 1'b1, 8'h00};
        tbl[10] = '{8'hFE, FUN_LDLO, 16'h00FF, 3'd0, 3'd0, 1'b1, 1'b0, 16'h12FF, 16'h12FF, 1'b1, 8'h00};
        tbl[11] = '{8'hFE, FUN_LDHI, 16'h00AA, 3'd0, 3'd0, 1'b1, 1'b0, 16'hAAFF, 16'hAAFF, 1'b1, 8'h00};
        tbl[12] = '{8'hFE, FUN_ASR,  16'h0000, 3'd0, 3'd0, 1'b1, 1'b0, 16'hD57F, 16'hD57F, 1'b1, 8'h00};
        tbl[13] = '{8'hDF, FUN_DEC,  16'h0000, 3'd5, 3'd5, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 8'h20};
        tbl[14] = '{8'hDF, FUN_SHL,  16'h0000, 3'd5, 3'd4, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 8'h20};
        tbl[15] = '{8'h00, FUN_INC,  16'h0000, 3'd5, 3'd3, 1'b1, 1'b0, 16'hFFFF, 16'hABCE, 1'b1, 8'h20};
        tbl[16] = '{8'h00, FUN_INC,  16'h0000, 3'd5, 3'd7, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b1, 8'h20};
        tbl[17] = '{8'hFF, FUN_CLR,  16'h5555, 3'd1, 3'd1, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b0, 8'h20};

        Reset = 1'b0; I = '0; RegSel = '1; FunSel = '0;
        OutASel = '0; OutBSel = '0; RdEn = 1'b0; ClrWrap = 1'b0;
        model_reset();
        #12;
        check("reset OutA", 32'(OutA), 32'h0);
        check("reset OutB", 32'(OutB), 32'h0);
        check("reset OutValid", 32'(OutValid), 32'h0);
        check("reset WrapFlag", 32'(WrapFlag), 32'h0);
        check_regs("reset");
        Reset = 1'b1;
        @(posedge Clock); #1;

        // directed table
        for (int t = 0; t < 18; t++) begin
            drive(tbl[t].regsel, tbl[t].fun, tbl[t].i, tbl[t].asel, tbl[t].bsel, tbl[t].rden, tbl[t].clr);
            check($sformatf("vec%0d OutA", t), 32'(OutA), 32'(tbl[t].ea));
            check($sformatf("vec%0d OutB", t), 32'(OutB), 32'(tbl[t].eb));
            check($sformatf("vec%0d OutValid", t), 32'(OutValid), 32'(tbl[t].ev));
            check($sformatf("vec%0d WrapFlag", t), 32'(WrapFlag), 32'(tbl[t].ew));
            check_regs($sformatf("vec%0d", t));
        end

        // randomized against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [7:0] rs;
            rs = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rs = 8'hFF;
            drive(rs, 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            check("rnd OutA", 32'(OutA), 32'(m_a));
            check("rnd OutB", 32'(OutB), 32'(m_b));
            check("rnd OutValid", 32'(OutValid), 32'(m_v));
            check("rnd WrapFlag", 32'(WrapFlag), 32'(m_wrap));
            check_regs("rnd");
        end

        // mid-cycle asynchronous reset with busy, nonzero state
        drive(8'hFE, FUN_CLR,  16'h0000, 3'd0, 3'd0, 1'b0, 1'b0);
        drive(8'hFE, FUN_DEC,  16'h0000, 3'd0, 3'd0, 1'b0, 1'b0);
        drive(8'h01, FUN_LOAD, 16'h5A5A, 3'd1, 3'd0, 1'b1, 1'b0);
        check("pre-rst OutA", 32'(OutA), 32'h5A5A);
        check("pre-rst OutB", 32'(OutB), 32'hFFFF);
        check("pre-rst WrapFlag", 32'(WrapFlag), 32'h01);
        RdEn = 1'b1;
        #3;
        Reset = 1'b0;
        model_reset();
        #1;
        check("async OutA", 32'(OutA), 32'h0);
        check("async OutB", 32'(OutB), 32'h0);
        check("async OutValid", 32'(OutValid), 32'h0);
        check("async WrapFlag", 32'(WrapFlag), 32'h0);
        check_regs("async");
        #2;
        Reset = 1'b1;

        // first edge after reset is an ordinary cycle
        drive(8'hFD, FUN_INC, 16'h0000, 3'd1, 3'd6, 1'b1, 1'b0);
        check("post-rst OutA", 32'(OutA), 32'h0001);
        check("post-rst OutB", 32'(OutB), 32'h0000);
        check("post-rst OutValid", 32'(OutValid), 32'h1);
        check("post-rst WrapFlag", 32'(WrapFlag), 32'h0);
        check_regs("post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
